shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Bus between the shift sequencer and the external shift register / host.
// The slave modport is the sequencer side; the master modport is the host side.
interface shift_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] sr_parallel_out;
  logic             sr_load;
  logic [WIDTH-1:0] sr_load_data;
  logic             sr_shift;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;

  modport slave (
    input  start, abort, tx_data, sr_parallel_out,
    output sr_load, sr_load_data, sr_shift, busy, done, rx_data
  );

  modport master (
    output start, abort, tx_data, sr_parallel_out,
    input  sr_load, sr_load_data, sr_shift, busy, done, rx_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Shift sequencer: loads a word into an external shift register, then issues
// WIDTH shift strobes spaced DIV clocks apart and captures the result.
//
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | one-cycle parallel-load strobe
//   SHIFT   | divider running, one shift strobe per DIV cycles
//   DONE    | one-cycle completion pulse, rx_data captured on exit
//
// Outputs are registered from the next-state decode so each output comes
// straight from a flop while still lining up with the state it belongs to.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  // Bit counter holds 0..WIDTH so it can never wrap before WIDTH strobes.
  localparam int              BW       = $clog2(WIDTH + 1);
  localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             sr_load_q, sr_load_d;
  logic             sr_shift_q, sr_shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    load_data_d = load_data_q;
    rx_d        = rx_q;
    case (state_q)
      S_IDLE: begin
        // abort outranks start so a stray abort can never launch a transfer
        if (!bus.abort && bus.start) begin
          state_d     = S_LOAD;
          load_data_d = bus.tx_data;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DONE: begin
        // abort is deliberately not looked at here
        state_d = S_IDLE;
        rx_d    = bus.sr_parallel_out;
      end
      default: state_d = S_IDLE;
    endcase

    sr_load_d  = (state_d == S_LOAD);
    sr_shift_d = (state_d == S_SHIFT) && (div_d == DIV_LAST);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, counters and output flops; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      load_data_q <= '0;
      rx_q        <= '0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      load_data_q <= load_data_d;
      rx_q        <= rx_d;
      sr_load_q   <= sr_load_d;
      sr_shift_q  <= sr_shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.sr_load      = sr_load_q;
  assign bus.sr_load_data = load_data_q;
  assign bus.sr_shift     = sr_shift_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rx_data      = rx_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: DIV=4 instance with a behavioural shift
// register, plus a DIV=1 instance for back-to-back transactions.
module tb_shift_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W)) ifa ();
  shift_sequencer_if #(.WIDTH(W)) ifb ();

  shift_sequencer #(.WIDTH(W), .DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  shift_sequencer #(.WIDTH(W), .DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // external shift register model for instance A
  logic [W-1:0] sr_a = '0;
  logic         si   = 1'b0;
  assign ifa.sr_parallel_out = sr_a;
  assign ifb.sr_parallel_out = 8'h00;

  always @(posedge clk) begin
    if (ifa.sr_load)       sr_a <= ifa.sr_load_data;
    else if (ifa.sr_shift) sr_a <= {sr_a[W-2:0], si};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor for instance A, sampled on the falling edge
  int cyc = 0, shifts_a = 0, dones_a = 0, busy_a = 0, loads_a = 0;
  int space_err = 0, strobe_err = 0, last_sh = 0;
  bit first_sh = 1'b1, prev_load = 1'b0, prev_shift = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (ifa.sr_load) begin loads_a++; first_sh = 1'b1; end
    if (ifa.sr_shift) begin
      shifts_a++;
      if (!first_sh && (cyc - last_sh) != 4) space_err++;
      first_sh = 1'b0;
      last_sh  = cyc;
    end
    if (ifa.done) dones_a++;
    if (ifa.busy) busy_a++;
    if ((ifa.sr_load && ifa.sr_shift) || (ifa.sr_load && prev_load) || (ifa.sr_shift && prev_shift))
      strobe_err++;
    prev_load  = ifa.sr_load;
    prev_shift = ifa.sr_shift;
  end

  // monitor for instance B: run lengths of busy, idle gaps and shift strobes
  int b_run = 0, b_gap = 0, s_run = 0;
  int b_runs[$], b_gaps[$], s_runs[$];
  always @(negedge clk) begin
    if (ifb.busy) begin
      if (b_gap > 0 && b_runs.size() > 0) b_gaps.push_back(b_gap);
      b_gap = 0;
      b_run++;
    end else begin
      if (b_run > 0) begin b_runs.push_back(b_run); b_run = 0; end
      b_gap++;
    end
    if (ifb.sr_shift) s_run++;
    else if (s_run > 0) begin s_runs.push_back(s_run); s_run = 0; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [W-1:0] d);
    ifa.tx_data = d;
    ifa.start   = 1'b1;
    step(1);
    ifa.start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (ifa.done !== 1'b1 && k < 200) begin step(1); k++; end
    chk({tag, "_done_seen"}, 32'(ifa.done), 32'd1);
  endtask

  task automatic wait_shifts(input int base, input int n, input string tag);
    int k = 0;
    while ((shifts_a - base) < n && k < 200) begin step(1); k++; end
    chk({tag, "_shift_reached"}, 32'(shifts_a - base), 32'(n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sr_load"},  32'(ifa.sr_load),      32'd0);
    chk({tag, "_sr_shift"}, 32'(ifa.sr_shift),     32'd0);
    chk({tag, "_busy"},     32'(ifa.busy),         32'd0);
    chk({tag, "_done"},     32'(ifa.done),         32'd0);
    chk({tag, "_ldata"},    32'(ifa.sr_load_data), 32'd0);
    chk({tag, "_rx"},       32'(ifa.rx_data),      32'd0);
  endtask

  int b_sh, b_dn, b_by, b_ld;

  task automatic snap();
    b_sh = shifts_a; b_dn = dones_a; b_by = busy_a; b_ld = loads_a;
  endtask

  initial begin
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.tx_data = '0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.tx_data = 8'h81;

    #3;
    chk_all_zero("reset");
    #20 rst_n = 1'b1;
    step(2);

    // full transaction, serial-in 1
    si = 1'b1;
    snap();
    kick(8'hA5);
    chk("t1_load",  32'(ifa.sr_load), 32'd1);
    chk("t1_busy",  32'(ifa.busy), 32'd1);
    chk("t1_ldata", 32'(ifa.sr_load_data), 32'hA5);
    wait_done("t1");
    step(1);
    chk("t1_idle",   32'(ifa.busy), 32'd0);
    chk("t1_rx",     32'(ifa.rx_data), 32'hFF);
    chk("t1_shifts", 32'(shifts_a - b_sh), 32'd8);
    chk("t1_dones",  32'(dones_a - b_dn), 32'd1);
    chk("t1_busycyc", 32'(busy_a - b_by), 32'd34);
    chk("t1_loads",  32'(loads_a - b_ld), 32'd1);
    chk("t1_spacing", 32'(space_err), 32'd0);

    // serial-in 0, abort during DONE is ignored
    si = 1'b0;
    snap();
    kick(8'h3C);
    step(1);
    chk("t2_sr_loaded", 32'(sr_a), 32'h3C);
    wait_done("t2");
    ifa.abort = 1'b1;
    step(1);
    ifa.abort = 1'b0;
    chk("t2_rx",     32'(ifa.rx_data), 32'h00);
    chk("t2_dones",  32'(dones_a - b_dn), 32'd1);
    chk("t2_idle",   32'(ifa.busy), 32'd0);
    chk("t2_shifts", 32'(shifts_a - b_sh), 32'd8);

    // start while busy is ignored
    si = 1'b1;
    snap();
    kick(8'hA5);
    wait_shifts(b_sh, 3, "t3");
    ifa.tx_data = 8'h11;
    ifa.start   = 1'b1;
    step(1);
    ifa.start   = 1'b0;
    wait_done("t3");
    step(1);
    chk("t3_ldata", 32'(ifa.sr_load_data), 32'hA5);
    chk("t3_rx",    32'(ifa.rx_data), 32'hFF);
    chk("t3_dones", 32'(dones_a - b_dn), 32'd1);
    chk("t3_loads", 32'(loads_a - b_ld), 32'd1);
    chk("t3_shifts", 32'(shifts_a - b_sh), 32'd8);
    step(3);
    chk("t3_no_queue", 32'(loads_a - b_ld), 32'd1);

    // abort after the 5th strobe
    si = 1'b0;
    snap();
    kick(8'h0F);
    wait_shifts(b_sh, 5, "t4");
    ifa.abort = 1'b1;
    step(1);
    ifa.abort = 1'b0;
    chk("t4_idle", 32'(ifa.busy), 32'd0);
    step(40);
    chk("t4_shifts", 32'(shifts_a - b_sh), 32'd5);
    chk("t4_dones",  32'(dones_a - b_dn), 32'd0);
    chk("t4_rx",     32'(ifa.rx_data), 32'hFF);

    // asynchronous reset mid-SHIFT
    snap();
    kick(8'hC3);
    wait_shifts(b_sh, 2, "t5");
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    #2 rst_n = 1'b1;
    step(1);
    chk("t5_dones", 32'(dones_a - b_dn), 32'd0);
    si = 1'b1;
    snap();
    kick(8'h5A);
    chk("t5_load", 32'(ifa.sr_load), 32'd1);
    wait_done("t5");
    step(1);
    chk("t5_busycyc", 32'(busy_a - b_by), 32'd34);
    chk("t5_rx",      32'(ifa.rx_data), 32'hFF);
    chk("t5_shifts",  32'(shifts_a - b_sh), 32'd8);

    // abort in IDLE beats start
    snap();
    ifa.tx_data = 8'h77;
    ifa.abort = 1'b1;
    ifa.start = 1'b1;
    step(1);
    ifa.abort = 1'b0;
    ifa.start = 1'b0;
    chk("t6_busy", 32'(ifa.busy), 32'd0);
    step(3);
    chk("t6_loads", 32'(loads_a - b_ld), 32'd0);
    chk("strobe_shape", 32'(strobe_err), 32'd0);

    // DIV=1, start held for 30 cycles
    ifb.start = 1'b1;
    step(30);
    ifb.start = 1'b0;
    step(20);
    chk("t7_nruns", 32'(b_runs.size()), 32'd3);
    foreach (b_runs[i]) chk("t7_busy_run", 32'(b_runs[i]), 32'd10);
    chk("t7_ngaps", 32'(b_gaps.size()), 32'd2);
    foreach (b_gaps[i]) chk("t7_gap", 32'(b_gaps[i]), 32'd1);
    chk("t7_nshruns", 32'(s_runs.size()), 32'd3);
    foreach (s_runs[i]) chk("t7_shift_run", 32'(s_runs[i]), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
